// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch condition resolve, 2-bit BHT predictor, registered redirect and statistics
// Resolves execute-stage branches, predicts fetch-stage branches and counts resolves/mispredicts.
module branch_unit #(
  parameter int         DATA_W    = 16,
  parameter int         ADDR_W    = 16,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_is_branch,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [2:0]        ex_cond,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_pred_taken,
  input  logic [DATA_W-1:0] rf_0,
  input  logic [DATA_W-1:0] rf_1,
  output logic              taken,
  output logic              redirect,
  output logic              redirect_taken,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] C_BZ   = 3'd0;
  localparam logic [2:0] C_BNZ  = 3'd1;
  localparam logic [2:0] C_BEQ  = 3'd2;
  localparam logic [2:0] C_BNEQ = 3'd3;
  localparam logic [2:0] C_BGT  = 3'd4;
  localparam logic [2:0] C_BLT  = 3'd5;
  localparam logic [2:0] C_BGE  = 3'd6;
  localparam logic [2:0] C_JMP  = 3'd7;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       ctr_d;
  logic             redirect_q, redirect_taken_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             eq, lt, cond_met, mispredict, train;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W-1:0];
  assign ex_idx = ex_pc[IDX_W-1:0];
  // Upper PC bits are deliberately dropped: aliasing PCs share a counter.
  assign unused_pc_bits = ^{if_pc[ADDR_W-1:IDX_W], ex_pc[ADDR_W-1:IDX_W]};

  assign eq = (rf_0 == rf_1);
  assign lt = ex_unsigned ? (rf_0 < rf_1) : ($signed(rf_0) < $signed(rf_1));

  always_comb begin
    cond_met = 1'b0;
    case (ex_cond)
      C_BZ:   cond_met = (rf_0 == '0);
      C_BNZ:  cond_met = (rf_0 != '0);
      C_BEQ:  cond_met = eq;
      C_BNEQ: cond_met = !eq;
      C_BGT:  cond_met = !lt && !eq;
      C_BLT:  cond_met = lt;
      C_BGE:  cond_met = !lt;
      C_JMP:  cond_met = 1'b1;
    endcase
  end

  assign taken      = ex_valid & cond_met;
  assign mispredict = ex_valid & (taken ^ ex_pred_taken);
  assign train      = ex_valid & (ex_cond != C_JMP);
  assign pred_taken = if_is_branch & bht_q[if_idx][1];

  always_comb begin
    ctr_d = bht_q[ex_idx];
    if (taken) begin
      if (bht_q[ex_idx] != 2'b11) ctr_d = bht_q[ex_idx] + 2'b01;
    end else begin
      if (bht_q[ex_idx] != 2'b00) ctr_d = bht_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
    end else if (train) begin
      bht_q[ex_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q       <= 1'b0;
      redirect_taken_q <= 1'b0;
    end else begin
      redirect_q       <= mispredict;
      redirect_taken_q <= mispredict & taken;
    end
  end

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (stat_clr) begin
      br_cnt_d      = '0;
      mispred_cnt_d = '0;
    end else begin
      if (ex_valid && (br_cnt_q != '1))        br_cnt_d      = br_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect       = redirect_q;
  assign redirect_taken = redirect_taken_q;
  assign br_cnt         = br_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution and prediction unit for the 4-stage CPU. Evaluates encoded branch conditions in signed or unsigned mode and predicts fetch-stage branches from a table of 2-bit saturating counters. Trains that table on every resolved conditional branch and emits a registered redirect on misprediction. Keeps saturating branch and mispredict statistics. Sits between fetch (predict port) and execute (resolve port); replaces the combinational branch-condition block.

## Interface
- DATA_W, 16, register-file operand width
- ADDR_W, 16, PC width
- BHT_DEPTH, 16, number of counter entries; power of 2, ≥2; IDX_W = log2(BHT_DEPTH)
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)
- CNT_W, 16, statistics counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- if_pc  in  ADDR_W  fetch PC; BHT index = if_pc[IDX_W-1:0]
- if_is_branch  in  1  predecode: fetched instruction is a branch or jump
- pred_taken  out  1  prediction to fetch (combinational)
- ex_valid  in  1  branch/jump present in execute this cycle
- ex_cond  in  3  0 BZ, 1 BNZ, 2 BEQ, 3 BNEQ, 4 BGT, 5 BLT, 6 BGE, 7 JMP
- ex_unsigned  in  1  1 = unsigned compare for BGT/BLT/BGE
- ex_pc  in  ADDR_W  PC of the executing branch (training index)
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- rf_0, rf_1  in  DATA_W  operands
- taken  out  1  resolved outcome (combinational, 0 when !ex_valid)
- redirect  out  1  registered mispredict pulse
- redirect_taken  out  1  registered: 1 = load branch target, 0 = load ex_pc+1
- stat_clr  in  1  synchronous clear of statistics
- br_cnt, mispred_cnt  out  CNT_W  resolved-branch and mispredict counts

## Operation
- Conditions: BZ rf_0==0; BNZ rf_0!=0; BEQ rf_0==rf_1; BNEQ rf_0!=rf_1; BGT rf_0>rf_1; BLT rf_0<rf_1; BGE rf_0>=rf_1; JMP always. GT/LT/GE are two's-complement when ex_unsigned=0, unsigned when 1. ex_unsigned is ignored for other codes.
- pred_taken = if_is_branch & bht[if_pc idx][1]. It is 0 when if_is_branch=0.
- mispredict = ex_valid & (taken != ex_pred_taken). A JMP with ex_pred_taken=0 mispredicts.
- Training, on ex_valid with ex_cond != JMP, index ex_pc[IDX_W-1:0]:
  - taken → counter+1, saturating at 3.
  - not taken → counter−1, saturating at 0.
  - JMP never writes the BHT.
- Statistics, each saturating at all-ones:
  - br_cnt +1 per ex_valid cycle.
  - mispred_cnt +1 per mispredict.
  - Priority: rst > stat_clr > increment. A clear in the same cycle as an increment yields 0.

## Timing
- Reset values: every BHT entry = CTR_INIT; redirect=0; redirect_taken=0; br_cnt=0; mispred_cnt=0.
- Inputs are ignored while rst=1: no training, no counting.
- The rst cycle itself must not produce a redirect in the following cycle.
- taken and pred_taken are combinational.
- pred_taken reflects BHT writes committed at prior edges only; there is no same-cycle write-to-read bypass. A simultaneous read and write of one index returns the old value.
- redirect and redirect_taken are valid exactly 1 cycle after the mispredicting ex_valid cycle. Both are held for one cycle, then return to 0.
- Back-to-back mispredicts give back-to-back redirect pulses. The pipeline flush is owned outside this block.
- The counter update and statistics are visible the cycle after the edge.
- Index aliasing: distinct PCs with equal low IDX_W bits share a counter. This is intentional.

## Test plan
- Reset, then if_pc=0x0003 with if_is_branch=1 → pred_taken=0 (CTR_INIT=01). Also check br_cnt=0, redirect=0.
- Train: ex_pc=0x0013, BEQ rf_0=rf_1=5, ex_pred_taken=0, ex_valid=1.
  - Resolve cycle: taken=1.
  - Next cycle: redirect=1, redirect_taken=1.
  - Then if_pc=0x0003 → pred_taken=1, since counter went 01→10 and 0x0013 aliases 0x0003.
- Saturation: 4 taken BNZ resolves at one index → counter 11; one not-taken → 10, still predicts taken. Then 3 not-taken → 00; a 4th keeps it at 00.
- Signed vs unsigned: BGT with rf_0=0xFFFF, rf_1=0x0001.
  - ex_unsigned=0 → taken=0.
  - ex_unsigned=1 → taken=1.
  - BGE with rf_0=rf_1=0x8000 → taken=1 in both modes.
- JMP with ex_pred_taken=0 → taken=1, redirect pulse 1 cycle later, BHT unchanged. Same JMP with ex_pred_taken=1 → no redirect.
- Statistics:
  - Preload mispred_cnt to all-ones with CNT_W=4 over 15 mispredicts; a 16th leaves it at 0xF.
  - stat_clr asserted together with ex_valid → both counts read 0 next cycle.
  - rst asserted mid-stream → all BHT entries back to 01 and no redirect on the following cycle.
